// File: rtl/parallel_bus_autoincrement_slave.sv
// Parallel bus slave bridging the Raspberry Pi master to a synchronous dual-port RAM.
// Multi-slice addressing, word assembly, optional auto-increment and a protocol-error counter.
module parallel_bus_autoincrement_slave #(
    parameter int WIDTH                 = 8,
    parameter int TRANSACTIONS_PER_WORD = 4,
    parameter int ADDRESS_TRANSACTIONS  = 2,
    parameter int AUTO_INCREMENT        = 1,
    parameter int ERROR_COUNTER_WIDTH   = 16,
    localparam int ADDRESS_WIDTH        = ADDRESS_TRANSACTIONS * WIDTH,
    localparam int WORD_WIDTH           = TRANSACTIONS_PER_WORD * WIDTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               bus_in,
    output logic [WIDTH-1:0]               bus_out,
    output logic                           bus_oe,
    input  logic                           read,
    input  logic                           register_select,
    input  logic                           enable,
    output logic                           ack_valid,
    output logic [ADDRESS_WIDTH-1:0]       mem_address,
    output logic [WORD_WIDTH-1:0]          mem_write_data,
    output logic                           mem_write_strobe,
    input  logic [WORD_WIDTH-1:0]          mem_read_data,
    output logic [ERROR_COUNTER_WIDTH-1:0] errors
);

    localparam int AC_W = (ADDRESS_TRANSACTIONS > 1) ? $clog2(ADDRESS_TRANSACTIONS) : 1;
    localparam int WC_W = (TRANSACTIONS_PER_WORD > 1) ? $clog2(TRANSACTIONS_PER_WORD) : 1;
    localparam logic [AC_W-1:0] A_MAX = AC_W'(ADDRESS_TRANSACTIONS - 1);
    localparam logic [WC_W-1:0] W_MAX = WC_W'(TRANSACTIONS_PER_WORD - 1);

    logic [WIDTH-1:0] bus_in_m, bus_in_s;
    logic             read_m, read_s;
    logic             register_select_m, register_select_s;
    logic             enable_m, enable_s, enable_prev;
    logic             ready_m, ready_s, armed;

    logic [AC_W-1:0] acount;
    logic [WC_W-1:0] wword, rword;

    logic [ADDRESS_TRANSACTIONS-1:0][WIDTH-1:0]  addr_sr, addr_next;
    logic [TRANSACTIONS_PER_WORD-1:0][WIDTH-1:0] write_sr, write_next;
    logic [TRANSACTIONS_PER_WORD-1:0][WIDTH-1:0] read_latch, read_src;

    logic action, act_addr, act_write, act_read, act_status;
    logic w_partial, r_partial, a_partial, err;

    // armed only after a genuine low level is seen, so an enable held across reset is ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_in_m          <= '0;
            bus_in_s          <= '0;
            read_m            <= 1'b0;
            read_s            <= 1'b0;
            register_select_m <= 1'b0;
            register_select_s <= 1'b0;
            enable_m          <= 1'b0;
            enable_s          <= 1'b0;
            enable_prev       <= 1'b0;
            ready_m           <= 1'b0;
            ready_s           <= 1'b0;
            armed             <= 1'b0;
        end else begin
            bus_in_m          <= bus_in;
            bus_in_s          <= bus_in_m;
            read_m            <= read;
            read_s            <= read_m;
            register_select_m <= register_select;
            register_select_s <= register_select_m;
            enable_m          <= enable;
            enable_s          <= enable_m;
            enable_prev       <= enable_s;
            ready_m           <= 1'b1;
            ready_s           <= ready_m;
            if (ready_s && !enable_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        action     = armed & enable_s & ~enable_prev;
        act_addr   = action & ~read_s & ~register_select_s;
        act_write  = action & ~read_s &  register_select_s;
        act_read   = action &  read_s &  register_select_s;
        act_status = action &  read_s & ~register_select_s;
        w_partial  = (wword != W_MAX);
        r_partial  = (rword != W_MAX);
        a_partial  = (acount != A_MAX);
        err        = (act_addr  & (w_partial | r_partial))
                   | (act_write & (r_partial | a_partial))
                   | (act_read  & (w_partial | a_partial));
    end

    always_comb begin
        addr_next          = addr_sr;
        addr_next[acount]  = bus_in_s;
        write_next         = write_sr;
        write_next[wword]  = bus_in_s;
        read_src           = (rword == W_MAX) ? mem_read_data : read_latch;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack_valid        <= 1'b0;
            bus_oe           <= 1'b0;
            bus_out          <= '0;
            mem_write_strobe <= 1'b0;
            mem_write_data   <= '0;
            mem_address      <= '0;
            read_latch       <= '0;
            errors           <= '0;
            addr_sr          <= '0;
            write_sr         <= '0;
            acount           <= A_MAX;
            wword            <= W_MAX;
            rword            <= W_MAX;
        end else begin
            mem_write_strobe <= 1'b0;
            ack_valid        <= enable_s & (action | ack_valid);
            bus_oe           <= read_s;

            if (err && errors != '1) begin
                errors <= errors + ERROR_COUNTER_WIDTH'(1);
            end

            // write increment lands one cycle after the strobe so the RAM sees the old address
            if (mem_write_strobe && AUTO_INCREMENT != 0) begin
                mem_address <= mem_address + ADDRESS_WIDTH'(1);
            end

            if (act_addr) begin
                addr_sr <= addr_next;
                if (acount == '0) begin
                    mem_address <= addr_next;
                    acount      <= A_MAX;
                end else begin
                    acount <= acount - AC_W'(1);
                end
                if (acount == '0 || w_partial || r_partial) begin
                    wword <= W_MAX;
                    rword <= W_MAX;
                end
            end

            if (act_write) begin
                rword    <= W_MAX;
                acount   <= A_MAX;
                write_sr <= write_next;
                if (wword == '0) begin
                    mem_write_strobe <= 1'b1;
                    mem_write_data   <= write_next;
                    wword            <= W_MAX;
                end else begin
                    wword <= wword - WC_W'(1);
                end
            end

            if (act_read) begin
                wword   <= W_MAX;
                acount  <= A_MAX;
                bus_out <= read_src[rword];
                if (rword == W_MAX) begin
                    read_latch <= mem_read_data;
                end
                if (rword == '0) begin
                    rword <= W_MAX;
                    if (AUTO_INCREMENT != 0) begin
                        mem_address <= mem_address + ADDRESS_WIDTH'(1);
                    end
                end else begin
                    rword <= rword - WC_W'(1);
                end
            end

            if (act_status) begin
                bus_out <= WIDTH'(errors);
            end
        end
    end

endmodule

// File: doc/parallel_bus_autoincrement_slave.md
Name: parallel_bus_autoincrement_slave

Overview:
Second-generation slave for the 8-bit-style parallel bus (bus/read/register_select/enable/ack_valid) driven by the Raspberry Pi master.
- Generalises the single-byte-address, fixed-width slave with a multi-transaction address, a parametrised data word, and optional address auto-increment for burst access.
- Adds input synchronisation, protocol-error detection and a pollable error counter.
- Sits between the bus pins and an external synchronous dual-port RAM: drives address, write data and write strobe; takes read data.

Parameters:
WIDTH, 8, bus width in bits
TRANSACTIONS_PER_WORD, 4, bus transactions per memory word (>=1); most significant slice first
ADDRESS_TRANSACTIONS, 2, bus transactions per address (>=1); most significant slice first
AUTO_INCREMENT, 1, 1 = mem_address advances by one after each completed word read or write
ERROR_COUNTER_WIDTH, 16, width of the saturating error counter
(derived) ADDRESS_WIDTH = ADDRESS_TRANSACTIONS*WIDTH; WORD_WIDTH = TRANSACTIONS_PER_WORD*WIDTH

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
bus_in  in  WIDTH  bus pins, input side
bus_out  out  WIDTH  data driven onto bus during reads
bus_oe  out  1  1 = drive bus (tristate enable for bus_entry_3state)
read  in  1  1 = read, 0 = write (asynchronous to clock)
register_select  in  1  0 = address/status, 1 = data
enable  in  1  master strobe, 1 = active (asynchronous)
ack_valid  out  1  acknowledge to master
mem_address  out  ADDRESS_WIDTH  RAM address (write and read port)
mem_write_data  out  WORD_WIDTH  assembled write word
mem_write_strobe  out  1  one-cycle write enable
mem_read_data  in  WORD_WIDTH  RAM output, 1-cycle synchronous read of mem_address
errors  out  ERROR_COUNTER_WIDTH  saturating protocol-error count

Behaviour:
Synchronisation
- read, register_select, enable and bus_in each pass through 2 flops (_s).
- The action cycle A is the cycle in which enable_s=1 and the previous enable_s=0; exactly one action per enable pulse.

Handshake
- ack_valid rises at A+1 and stays 1 while enable_s=1.
- ack_valid falls the cycle after enable_s falls.
- bus_out is valid no later than A+1.
- bus_oe = registered read_s, independent of enable.

Address action (read_s=0, register_select_s=0)
- Slice is stored into address shift register at index acount; acount counts ADDRESS_TRANSACTIONS-1 down to 0.
- On the final slice, mem_address loads the full assembled value at A+1, acount reloads, and wword/rword reload to TRANSACTIONS_PER_WORD-1.
- If wword or rword was not at TRANSACTIONS_PER_WORD-1 at this point, errors increments by 1 (once per action).

Write action (read_s=0, register_select_s=1)
- write_data[wword] <= bus_in_s; wword decrements.
- On the wword==0 action: mem_write_strobe=1 for exactly cycle A+1 with mem_write_data = concatenated slices, and wword reloads.
- If AUTO_INCREMENT, mem_address increments at A+2, wrapping from all-ones to 0.

Read action (read_s=1, register_select_s=1)
- On rword==TRANSACTIONS_PER_WORD-1, mem_read_data is snapshotted into read_latch at A.
- bus_out <= read_latch slice rword; rword decrements.
- On rword==0, rword reloads; if AUTO_INCREMENT, mem_address increments at A+1.
- RAM output is valid by the next word's first action because enable pulses are at least 4 cycles apart.

Status read (read_s=1, register_select_s=0)
- bus_out <= errors[WIDTH-1:0], zero-extended if ERROR_COUNTER_WIDTH<WIDTH.
- Does not disturb any counter.

Protocol errors (errors +1 each, saturating at all-ones)
- Address slice while a word is partial (see above).
- Write action while rword partial: rword reloads, then the write proceeds.
- Read action while wword partial: partial write data discarded, wword reloads, then the read proceeds.
- Data action while acount partial: acount reloads, mem_address unchanged.
- At most +1 per action cycle.

Reset
- ack_valid, bus_oe, bus_out, mem_write_strobe, mem_write_data, mem_address, read_latch, errors: all 0.
- acount, wword, rword reload to their maxima; synchroniser flops 0.
- Reset mid-word discards partial data and issues no strobe.
- An enable held high across reset release does not create an action until it falls and rises again.

Test Plan:
1. Address 0xab,0x4c; write 0x31,0x23,0x2a,0x12 -> single mem_write_strobe with mem_address=0xab4c, mem_write_data=0x31232a12; mem_address=0xab4d two cycles later; errors=0.
2. Address 0xab4c; four reads with RAM holding 0x31232a12 there -> bus_out sequence 0x31,0x23,0x2a,0x12, each acked; mem_address ends at 0xab4d.
3. Auto-increment burst: address 0xffff, write 2 words -> strobes at 0xffff then 0x0000 (wrap).
4. Protocol errors: write 2 slices, then address slice 0x12 -> errors=1, no strobe. Then status read -> bus_out=0x01 with ack_valid.
5. Handshake timing: enable held high 20 cycles -> exactly one action. ack_valid rises 3 cycles after raw enable rises, falls 3 cycles after raw enable falls.
6. Reset asserted after the third write slice -> no strobe, all outputs 0. A following full 4-slice write stores correctly; errors=0.
